// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared defaults, tick arithmetic, state type and slot indexing for sa_ctrl
package sa_pkg;

    localparam int SA_DATAWIDTH = 16;
    localparam int SA_N_SIZE    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

    // Ticks 0 .. 3N-3 carry operands; tick 3N-2 is the accumulator-clear tick.
    function automatic int sa_n_ticks(input int n);
        return 3 * n - 2;
    endfunction

    function automatic int sa_cw(input int n);
        return $clog2(3 * n - 1);
    endfunction

    function automatic int sa_slot(input int row, input int col, input int n);
        return row * n + col;
    endfunction

endpackage

// File: rtl/sa_skew_mux.sv
// rtl/sa_skew_mux.sv - skewed edge-lane selector: lane l at tick t carries element k = t-l of its row/column
module sa_skew_mux
    import sa_pkg::*;
#(
    parameter int DATAWIDTH = SA_DATAWIDTH,
    parameter int N_SIZE    = SA_N_SIZE,
    parameter int CW        = sa_cw(SA_N_SIZE),
    parameter bit TRANSPOSE = 1'b0
) (
    input  logic                                 en,
    input  logic [CW-1:0]                        count,
    input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]   mat,
    output logic [N_SIZE*DATAWIDTH-1:0]          lanes
);

    // TRANSPOSE=0: lane l = row l, walking columns (A). TRANSPOSE=1: lane l = column l, walking rows (B).
    always_comb begin
        lanes = '0;
        for (int l = 0; l < N_SIZE; l++) begin
            for (int k = 0; k < N_SIZE; k++) begin
                if (en && (int'(count) == l + k)) begin
                    if (TRANSPOSE)
                        lanes[l*DATAWIDTH +: DATAWIDTH] = mat[sa_slot(k, l, N_SIZE)*DATAWIDTH +: DATAWIDTH];
                    else
                        lanes[l*DATAWIDTH +: DATAWIDTH] = mat[sa_slot(l, k, N_SIZE)*DATAWIDTH +: DATAWIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/sa_ctrl.sv
// rtl/sa_ctrl.sv - systolic array sequencer: operand skew, tick broadcast, result capture (optional SA_CTRL_PERF_EN job counter)
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int  DATAWIDTH = SA_DATAWIDTH,
    parameter int  N_SIZE    = SA_N_SIZE,
    localparam int N_TICKS   = sa_n_ticks(N_SIZE),
    localparam int CW        = sa_cw(N_SIZE)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]     a_mat,
    input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]     b_mat,
    input  logic                                   abort,
    output logic [CW-1:0]                          count,
    output logic [N_SIZE*DATAWIDTH-1:0]            a_edge,
    output logic [N_SIZE*DATAWIDTH-1:0]            b_edge,
    input  logic [N_SIZE*N_SIZE*2*DATAWIDTH-1:0]   c_array,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [N_SIZE*N_SIZE*2*DATAWIDTH-1:0]   c_mat,
    output logic                                   busy
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [15:0]                            perf_jobs
`endif
);

    localparam int            NN        = N_SIZE * N_SIZE;
    localparam int            RW        = 2 * DATAWIDTH;
    localparam logic [CW-1:0] LAST_TICK = CW'(N_TICKS);

    sa_state_e               state;
    sa_state_e               state_nxt;
    logic [CW-1:0]           count_nxt;
    logic                    accept;
    logic                    complete;
    logic                    run;
    logic [NN*DATAWIDTH-1:0] a_buf;
    logic [NN*DATAWIDTH-1:0] b_buf;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                count_nxt = LAST_TICK;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                    count_nxt = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    count_nxt = LAST_TICK;
                end else if (count == LAST_TICK) begin
                    state_nxt = DONE;
                end else begin
                    count_nxt = count + CW'(1);
                end
            end
            DONE: begin
                count_nxt = LAST_TICK;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    state_nxt = IDLE;
                    complete  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = LAST_TICK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= LAST_TICK;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Operand buffers intentionally survive reset; only a new accept overwrites them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_buf <= a_mat;
            b_buf <= b_mat;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign run       = (state == RUN);

    sa_skew_mux #(
        .DATAWIDTH (DATAWIDTH),
        .N_SIZE    (N_SIZE),
        .CW        (CW),
        .TRANSPOSE (1'b0)
    ) u_a_skew (
        .en    (run),
        .count (count),
        .mat   (a_buf),
        .lanes (a_edge)
    );

    sa_skew_mux #(
        .DATAWIDTH (DATAWIDTH),
        .N_SIZE    (N_SIZE),
        .CW        (CW),
        .TRANSPOSE (1'b1)
    ) u_b_skew (
        .en    (run),
        .count (count),
        .mat   (b_buf),
        .lanes (b_edge)
    );

    // PE(i,j) sees its last operand pair (k = N-1) on tick i+j+N-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_mat <= '0;
        end else if (run) begin
            for (int i = 0; i < N_SIZE; i++) begin
                for (int j = 0; j < N_SIZE; j++) begin
                    if (int'(count) == i + j + N_SIZE - 1)
                        c_mat[sa_slot(i, j, N_SIZE)*RW +: RW] <= c_array[sa_slot(i, j, N_SIZE)*RW +: RW];
                end
            end
        end
    end

`ifdef SA_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            perf_jobs <= '0;
        else if (complete)
            perf_jobs <= perf_jobs + 16'd1;
    end
`endif

endmodule
